// File: rtl/fetch_unit.sv
// IF stage: owns the PC, issues one-outstanding instruction fetches, and feeds IF/ID through a 1-entry skid buffer.
// Optional FETCH_PERF_EN adds saturating stall-cycle and flush counters.
module fetch_unit #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            flush,
   input  logic [XLEN-1:0] branch_target,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] ifid_instr,
   output logic [XLEN-1:0] ifid_pc,
   output logic            ifid_valid,
   output logic            fetch_busy
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]     perf_stall_cycles,
   output logic [31:0]     perf_flush_count
`endif
);

   typedef enum logic {S_REQ, S_WAIT} state_t;

   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   state_t          state, state_nxt;
   logic [XLEN-1:0] pc, pc_nxt;
   logic [XLEN-1:0] req_pc, req_pc_nxt;
   logic            drop, drop_nxt;
   logic            skid_valid, skid_valid_nxt;
   logic            skid_load;
   logic [XLEN-1:0] skid_instr, skid_pc;
   logic [XLEN-1:0] ifid_instr_nxt, ifid_pc_nxt;
   logic            ifid_valid_nxt;
   logic            resp_live;

   // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc;
      req_pc_nxt     = req_pc;
      drop_nxt       = drop;
      skid_valid_nxt = skid_valid;
      skid_load      = 1'b0;
      ifid_instr_nxt = ifid_instr;
      ifid_pc_nxt    = ifid_pc;
      ifid_valid_nxt = ifid_valid;

      imem_req   = (state == S_REQ) && !skid_valid && !flush && !rst;
      imem_addr  = pc & ALIGN_MASK;
      fetch_busy = (state == S_WAIT) && !rst;
      resp_live  = (state == S_WAIT) && imem_rvalid && !drop;

      if (flush) begin
         // Redirect wins over stall: kill IF/ID and the skid, and drop a response still in flight.
         pc_nxt         = branch_target & ALIGN_MASK;
         skid_valid_nxt = 1'b0;
         ifid_instr_nxt = NOP_INSTR;
         ifid_valid_nxt = 1'b0;
         if (state == S_WAIT) begin
            if (imem_rvalid) begin
               state_nxt = S_REQ;
               drop_nxt  = 1'b0;
            end else begin
               drop_nxt  = 1'b1;
            end
         end
      end else begin
         case (state)
            S_REQ: begin
               if (imem_req && imem_gnt) begin
                  state_nxt  = S_WAIT;
                  req_pc_nxt = pc;
                  pc_nxt     = pc + XLEN'(4);
               end
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  state_nxt = S_REQ;
                  drop_nxt  = 1'b0;
               end
            end
            default: state_nxt = S_REQ;
         endcase

         if (resp_live && !stall && !skid_valid) begin
            ifid_instr_nxt = imem_rdata;
            ifid_pc_nxt    = req_pc;
            ifid_valid_nxt = 1'b1;
         end else if (resp_live) begin
            skid_valid_nxt = 1'b1;
            skid_load      = 1'b1;
         end else if (!stall && skid_valid) begin
            ifid_instr_nxt = skid_instr;
            ifid_pc_nxt    = skid_pc;
            ifid_valid_nxt = 1'b1;
            skid_valid_nxt = 1'b0;
         end else if (!stall) begin
            ifid_instr_nxt = NOP_INSTR;
            ifid_valid_nxt = 1'b0;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_REQ;
         pc         <= RESET_PC;
         req_pc     <= '0;
         drop       <= 1'b0;
         skid_valid <= 1'b0;
         ifid_instr <= NOP_INSTR;
         ifid_pc    <= '0;
         ifid_valid <= 1'b0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         req_pc     <= req_pc_nxt;
         drop       <= drop_nxt;
         skid_valid <= skid_valid_nxt;
         ifid_instr <= ifid_instr_nxt;
         ifid_pc    <= ifid_pc_nxt;
         ifid_valid <= ifid_valid_nxt;
      end
   end

   // NOTE: skid payload is qualified by skid_valid, so it carries no reset.
   always_ff @(posedge clk) begin
      if (skid_load) begin
         skid_instr <= imem_rdata;
         skid_pc    <= req_pc;
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cycles <= '0;
         perf_flush_count  <= '0;
      end else begin
         if (stall && !flush && (perf_stall_cycles != 32'hFFFF_FFFF))
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (flush && (perf_flush_count != 32'hFFFF_FFFF))
            perf_flush_count <= perf_flush_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory model with programmable latency plus a scoreboard that expects IF/ID to
// deliver instructions in strict PC order, restarting at the target on flush and at RESET_PC on reset.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk, rst, stall, flush, imem_req, imem_gnt, imem_rvalid, ifid_valid, fetch_busy;
   logic [31:0] branch_target, imem_addr, imem_rdata, ifid_instr, ifid_pc;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_stall_cycles, perf_flush_count;
`endif

   fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .branch_target(branch_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid), .fetch_busy(fetch_busy)
`ifdef FETCH_PERF_EN
      , .perf_stall_cycles(perf_stall_cycles), .perf_flush_count(perf_flush_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // memory model: one outstanding request, response lat cycles after the grant
   bit          mem_busy   = 1'b0;
   logic [31:0] mem_addr   = '0;
   int          mem_cnt    = 0;
   int          fixed_lat  = 1;   // 0 selects a random latency of 1..5
   bit          rand_gnt   = 1'b0;
   logic [31:0] mem_key    = '0;

   // scoreboard
   logic [31:0] exp_pc   = RESET_PC;
   int          consumed = 0;
   logic [31:0] seen_pcs[$];
   int unsigned m_stall  = 0;
   int unsigned m_flush  = 0;

   logic        last_req, last_gnt, last_busy;
   logic [31:0] last_addr;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return a ^ mem_key;
   endfunction

   task automatic cycle(input bit r, input bit s, input bit f, input logic [31:0] tgt);
      rst = r; stall = s; flush = f; branch_target = tgt;
      imem_gnt = 1'b0;
      if (mem_busy && mem_cnt == 0) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_fn(mem_addr);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
      #1;
      last_req  = imem_req;
      last_addr = imem_addr;
      last_busy = fetch_busy;
      if (imem_req && !mem_busy && (!rand_gnt || $urandom_range(0, 2) != 0)) imem_gnt = 1'b1;
      last_gnt = imem_gnt;

      if (r || f) begin
         checks++;
         if (last_req !== 1'b0) begin
            errors++; $display("FAIL req_blocked: imem_req=%b required 0 (rst=%b flush=%b)", last_req, r, f);
         end
      end
      if (last_req === 1'b1) begin
         checks++;
         if (last_addr[1:0] !== 2'b00) begin
            errors++; $display("FAIL addr_align: imem_addr=%h required word aligned", last_addr);
         end
      end
      if (!r && !f && !s && ifid_valid === 1'b1) begin
         checks++;
         if (ifid_pc !== exp_pc || ifid_instr !== mem_fn(exp_pc)) begin
            errors++;
            $display("FAIL stream: ifid pc=%h instr=%h required pc=%h instr=%h", ifid_pc, ifid_instr, exp_pc, mem_fn(exp_pc));
         end
         seen_pcs.push_back(ifid_pc);
         exp_pc = exp_pc + 32'd4;
         consumed++;
      end
      if (!r && ifid_valid === 1'b0) begin
         checks++;
         if (ifid_instr !== NOP) begin
            errors++; $display("FAIL bubble_instr: ifid_instr=%h required %h", ifid_instr, NOP);
         end
      end
      if (r) begin
         m_stall = 0; m_flush = 0;
      end else begin
         if (s && !f && m_stall != 32'hFFFF_FFFF) m_stall++;
         if (f && m_flush != 32'hFFFF_FFFF) m_flush++;
      end

      @(posedge clk);
      if (r) exp_pc = RESET_PC;
      else if (f) exp_pc = {tgt[31:2], 2'b00};
      if (imem_rvalid) mem_busy = 1'b0;
      else if (mem_busy) mem_cnt--;
      if (imem_gnt) begin
         mem_busy = 1'b1;
         mem_addr = last_addr;
         mem_cnt  = ((fixed_lat != 0) ? fixed_lat : $urandom_range(1, 5)) - 1;
      end
      #1;
   endtask

   task automatic do_reset(input bit clear_mem);
      if (clear_mem) mem_busy = 1'b0;
      cycle(1, 0, 0, 32'h0);
      consumed = 0;
      seen_pcs.delete();
   endtask

   task automatic wait_gnt(input bit match, input logic [31:0] addr, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         cycle(0, 0, 0, 32'h0);
         if (last_gnt && (!match || last_addr == addr)) ok = 1'b1;
      end
   endtask

   task automatic wait_consumed(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 80 && !ok; i++) begin
         cycle(0, 0, 0, 32'h0);
         if (consumed >= n) ok = 1'b1;
      end
   endtask

   task automatic test_reset;
      fixed_lat = 1; rand_gnt = 1'b0; mem_key = '0;
      do_reset(1);
      cycle(1, 0, 0, 32'h0);
      checks++;
      if (ifid_valid !== 1'b0 || ifid_instr !== NOP || ifid_pc !== 32'h0) begin
         errors++; $display("FAIL reset_ifid: valid=%b instr=%h pc=%h required 0/%h/0", ifid_valid, ifid_instr, ifid_pc, NOP);
      end
      checks++;
      if (fetch_busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy: fetch_busy=%b required 0", fetch_busy);
      end
`ifdef FETCH_PERF_EN
      checks++;
      if (perf_stall_cycles !== 32'h0 || perf_flush_count !== 32'h0) begin
         errors++; $display("FAIL reset_perf: stall=%0d flush=%0d required 0/0", perf_stall_cycles, perf_flush_count);
      end
`endif
      cycle(0, 0, 0, 32'h0);
      checks++;
      if (last_req !== 1'b1 || last_addr !== RESET_PC) begin
         errors++; $display("FAIL reset_first_req: req=%b addr=%h required 1/%h", last_req, last_addr, RESET_PC);
      end
   endtask

   task automatic test_zero_wait;
      int first_vis = -1;
      fixed_lat = 1; rand_gnt = 1'b0; mem_key = '0;
      do_reset(1);
      for (int i = 0; i < 7; i++) begin
         cycle(0, 0, 0, 32'h0);
         if (first_vis < 0 && ifid_valid === 1'b1) first_vis = i + 1;
      end
      checks++;
      if (first_vis != 2) begin
         errors++; $display("FAIL zw_latency: first valid in cycle %0d required 2", first_vis);
      end
      checks++;
      if (consumed != 3 || seen_pcs[0] !== 32'h0 || seen_pcs[1] !== 32'h4 || seen_pcs[2] !== 32'h8) begin
         errors++; $display("FAIL zw_stream: consumed=%0d required 3 instrs 0,4,8", consumed);
      end
   endtask

   task automatic test_stall;
      bit ok = 1'b0;
      fixed_lat = 1; rand_gnt = 1'b0; mem_key = '0;
      do_reset(1);
      for (int i = 0; i < 20 && !ok; i++) begin
         if (ifid_valid === 1'b1 && ifid_pc === 32'h4) ok = 1'b1;
         else cycle(0, 0, 0, 32'h0);
      end
      checks++;
      if (!ok) begin
         errors++; $display("FAIL stall_setup: ifid pc 0x4 not seen, got %h required 4", ifid_pc);
      end
      for (int i = 0; i < 3; i++) begin
         cycle(0, 1, 0, 32'h0);
         checks++;
         if (ifid_valid !== 1'b1 || ifid_pc !== 32'h4) begin
            errors++; $display("FAIL stall_hold: valid=%b pc=%h required 1/4", ifid_valid, ifid_pc);
         end
      end
      checks++;
      if (last_req !== 1'b0) begin
         errors++; $display("FAIL stall_skid_noreq: imem_req=%b required 0", last_req);
      end
      cycle(0, 0, 0, 32'h0);
      checks++;
      if (ifid_valid !== 1'b1 || ifid_pc !== 32'h8 || ifid_instr !== 32'h8) begin
         errors++; $display("FAIL stall_release: valid=%b pc=%h instr=%h required 1/8/8", ifid_valid, ifid_pc, ifid_instr);
      end
      cycle(0, 0, 0, 32'h0);
      checks++;
      if (seen_pcs.size() != 3) begin
         errors++; $display("FAIL stall_count: delivered=%0d required 3", seen_pcs.size());
      end
   endtask

   task automatic test_flush_wait;
      bit ok;
      int n = 0;
      fixed_lat = 3;
      wait_gnt(1, 32'h10, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL fw_setup: grant for 0x10 not seen, got %h required 10", last_addr);
      end
      cycle(0, 0, 1, 32'h100);
      checks++;
      if (ifid_valid !== 1'b0 || ifid_instr !== NOP || last_busy !== 1'b1) begin
         errors++; $display("FAIL fw_bubble: valid=%b instr=%h busy=%b required 0/%h/1", ifid_valid, ifid_instr, last_busy, NOP);
      end
      fixed_lat = 1;
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         cycle(0, 0, 0, 32'h0);
         n++;
         if (last_req === 1'b1) ok = 1'b1;
      end
      checks++;
      if (!ok || n != 3 || last_addr !== 32'h100) begin
         errors++; $display("FAIL fw_redirect: req after %0d cycles addr=%h required 3 cycles addr 100", n, last_addr);
      end
      consumed = 0;
      wait_consumed(1, ok);
      checks++;
      if (!ok || seen_pcs[seen_pcs.size()-1] !== 32'h100) begin
         errors++; $display("FAIL fw_first: first after flush pc=%h required 100", seen_pcs[seen_pcs.size()-1]);
      end
   endtask

   task automatic test_flush_stall;
      bit ok;
      fixed_lat = 1;
      for (int i = 0; i < 4; i++) cycle(0, 1, 0, 32'h0);
      checks++;
      if (last_req !== 1'b0) begin
         errors++; $display("FAIL fs_skid_full: imem_req=%b required 0", last_req);
      end
      cycle(0, 1, 1, 32'h203);
      checks++;
      if (ifid_valid !== 1'b0 || ifid_instr !== NOP) begin
         errors++; $display("FAIL fs_bubble: valid=%b instr=%h required 0/%h", ifid_valid, ifid_instr, NOP);
      end
      cycle(0, 0, 0, 32'h0);
      checks++;
      if (last_req !== 1'b1 || last_addr !== 32'h200) begin
         errors++; $display("FAIL fs_redirect: req=%b addr=%h required 1/200", last_req, last_addr);
      end
      consumed = 0;
      wait_consumed(2, ok);
      checks++;
      if (!ok || seen_pcs[seen_pcs.size()-1] !== 32'h204) begin
         errors++; $display("FAIL fs_stream: last pc=%h required 204", seen_pcs[seen_pcs.size()-1]);
      end
   endtask

   task automatic test_wrap;
      bit ok;
      fixed_lat = 1;
      cycle(0, 0, 1, 32'hFFFF_FFF8);
      consumed = 0;
      seen_pcs.delete();
      wait_consumed(3, ok);
      checks++;
      if (!ok || seen_pcs[0] !== 32'hFFFF_FFF8 || seen_pcs[1] !== 32'hFFFF_FFFC || seen_pcs[2] !== 32'h0) begin
         errors++; $display("FAIL wrap: consumed=%0d last pc=%h required F8,FC,0", consumed, ifid_pc);
      end
   endtask

   task automatic test_reset_midwait;
      bit ok;
      fixed_lat = 3;
      wait_gnt(0, 32'h0, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL rw_setup: no grant seen, got req=%b required a grant", last_req);
      end
      cycle(0, 0, 0, 32'h0);
      cycle(1, 0, 0, 32'h0);
      consumed = 0;
      seen_pcs.delete();
      checks++;
      if (ifid_valid !== 1'b0 || fetch_busy !== 1'b0) begin
         errors++; $display("FAIL rw_reset: valid=%b busy=%b required 0/0", ifid_valid, fetch_busy);
      end
`ifdef FETCH_PERF_EN
      checks++;
      if (perf_stall_cycles !== 32'h0 || perf_flush_count !== 32'h0) begin
         errors++; $display("FAIL rw_perf: stall=%0d flush=%0d required 0/0", perf_stall_cycles, perf_flush_count);
      end
`endif
      fixed_lat = 1;
      cycle(0, 0, 0, 32'h0);
      checks++;
      if (last_req !== 1'b1 || last_addr !== RESET_PC || ifid_valid !== 1'b0) begin
         errors++; $display("FAIL rw_stale: req=%b addr=%h valid=%b required 1/%h/0", last_req, last_addr, ifid_valid, RESET_PC);
      end
      wait_consumed(1, ok);
      checks++;
      if (!ok || seen_pcs[0] !== RESET_PC) begin
         errors++; $display("FAIL rw_first: first pc=%h required %h", seen_pcs[0], RESET_PC);
      end
   endtask

   task automatic test_random;
      bit s, f;
      logic [31:0] tgt;
      fixed_lat = 0; rand_gnt = 1'b1;
      do_reset(1);
      mem_key = $urandom;
      for (int i = 0; i < 3000; i++) begin
         s   = ($urandom_range(0, 3) == 0);
         f   = ($urandom_range(0, 19) == 0);
         tgt = ($urandom_range(0, 1) == 0) ? $urandom : {20'h0, 12'($urandom)};
         cycle(0, s, f, tgt);
      end
      checks++;
      if (consumed < 100) begin
         errors++; $display("FAIL rand_progress: delivered=%0d required at least 100", consumed);
      end
`ifdef FETCH_PERF_EN
      checks++;
      if (perf_stall_cycles !== m_stall || perf_flush_count !== m_flush) begin
         errors++; $display("FAIL rand_perf: stall=%0d flush=%0d required %0d/%0d", perf_stall_cycles, perf_flush_count, m_stall, m_flush);
      end
`endif
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_target = '0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      test_reset();
      test_zero_wait();
      test_stall();
      test_flush_wait();
      test_flush_stall();
      test_wrap();
      test_reset_midwait();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog");
   end

endmodule
